// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, control fields.
// Purely declarative; no latency or flow-control behaviour lives here.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0001;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_LUI  = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;
  localparam logic [1:0] EXT_SHL2 = 2'b11;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC    = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_REG   = 2'b11;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_UNK
  } instr_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic [1:0] ext_op;
  } ctrl_t;

  // Immediate extension is a property of the instruction alone, so DECODE and EXEC share it.
  function automatic logic [1:0] ext_sel(input instr_t i);
    case (i)
      I_LUI:       return EXT_LUI;
      I_LW, I_SW:  return EXT_SIGN;
      I_BEQ:       return EXT_SHL2;
      default:     return EXT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational map from {state, op, func, zero} to the datapath control bundle.
// Zero latency; no flow control (ready gating is applied by the parent).
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output instr_t     instr,
  output ctrl_t      ctrl
);

  always_comb begin
    instr = I_UNK;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_JR:   instr = I_JR;
          default: instr = I_UNK;
        endcase
      end
      OP_ORI:  instr = I_ORI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      OP_BEQ:  instr = I_BEQ;
      OP_LUI:  instr = I_LUI;
      OP_JAL:  instr = I_JAL;
      default: instr = I_UNK;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.pc_sel   = PC_PLUS4;
      end
      S_DECODE: ctrl.ext_op = ext_sel(instr);
      S_EXEC: begin
        ctrl.ext_op = ext_sel(instr);
        case (instr)
          I_ADDU: ctrl.alu_ctrl = ALU_ADD;
          I_SUBU: ctrl.alu_ctrl = ALU_SUB;
          I_ORI: begin
            ctrl.alu_ctrl = ALU_OR;
            ctrl.alu_src  = 1'b1;
          end
          I_LUI, I_LW, I_SW: begin
            ctrl.alu_ctrl = ALU_ADD;
            ctrl.alu_src  = 1'b1;
          end
          I_BEQ: begin
            ctrl.alu_ctrl = ALU_SUB;
            ctrl.pc_write = zero;
            ctrl.pc_sel   = PC_BRANCH;
          end
          I_JAL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_sel     = PC_JUMP;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = DST_RA;
            ctrl.mem_to_reg = WB_PC;
          end
          I_JR: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_sel   = PC_REG;
          end
          default: ctrl = '0;
        endcase
      end
      S_MEM: begin
        // Address computation stays live for the whole access.
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.mem_read  = (instr == I_LW);
        ctrl.mem_write = (instr == I_SW);
      end
      S_WB: begin
        ctrl.reg_write = 1'b1;
        case (instr)
          I_ADDU, I_SUBU: ctrl.reg_dst    = DST_RD;
          I_LW:           ctrl.mem_to_reg = WB_MEM;
          default:        ctrl.reg_dst    = DST_RT;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with opcode latch and retire counter.
// Outputs are combinational from state; FETCH stalls on imem_ready, MEM holds strobes until dmem_ready.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             Zero,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic [3:0]       ALUCtrl,
  output logic [1:0]       ExtOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, func_q;
  logic [CNT_W-1:0] count_q;
  instr_t           instr;
  ctrl_t            ctrl, ctrl_o;
  logic             imem_ok, dmem_ok, done;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^Instr[25:6];
  assign imem_ok = MEM_HS ? imem_ready : 1'b1;
  assign dmem_ok = MEM_HS ? dmem_ready : 1'b1;

  mc_decode u_decode (
    .state (state_q),
    .op    (op_q),
    .func  (func_q),
    .zero  (Zero),
    .instr (instr),
    .ctrl  (ctrl)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_FETCH:  if (imem_ok) state_d = S_DECODE;
      S_DECODE: begin
        if (instr == I_UNK) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (instr)
          I_BEQ, I_JAL, I_JR: begin
            state_d = S_FETCH;
            done    = 1'b1;
          end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ok) begin
          if (instr == I_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            done    = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        done    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ok) begin
        op_q   <= Instr[31:26];
        func_q <= Instr[5:0];
      end
      if (done) count_q <= count_q + CNT_W'(1);
    end
  end

  // Reset and an un-acked fetch both force every enable low, not just the strobes.
  assign ctrl_o = (reset || (state_q == S_FETCH && !imem_ok)) ? '0 : ctrl;

  assign PCWrite     = ctrl_o.pc_write;
  assign PCSel       = ctrl_o.pc_sel;
  assign IRWrite     = ctrl_o.ir_write;
  assign RegWrite    = ctrl_o.reg_write;
  assign RegDst      = ctrl_o.reg_dst;
  assign MemtoReg    = ctrl_o.mem_to_reg;
  assign MemRead     = ctrl_o.mem_read;
  assign MemWrite    = ctrl_o.mem_write;
  assign ALUSrc      = ctrl_o.alu_src;
  assign ALUCtrl     = ctrl_o.alu_ctrl;
  assign ExtOp       = ctrl_o.ext_op;
  assign state       = reset ? 3'd0 : state_q;
  assign instr_done  = done & ~reset;
  assign instr_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: per-instruction expected summaries vs observed behaviour.
`timescale 1ns/1ps
module tb_mc_controller;

  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4;
  localparam int C_SW = 5, C_BEQ = 6, C_LUI = 7, C_JAL = 8, C_UNK = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        imem_ready = 1'b1, dmem_ready = 1'b1, Zero = 1'b1;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, instr_done;
  logic [1:0]  PCSel, RegDst, MemtoReg, ExtOp;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  logic [31:0] instr_count;

  logic [31:0] instr2 = 32'hFC000000;
  logic        rdy2 = 1'b0;
  logic        pcw2, irw2, rw2, mr2, mw2, as2, done2;
  logic [1:0]  pcs2, rd2, mtr2, ext2;
  logic [3:0]  alu2;
  logic [2:0]  st2;
  logic [3:0]  count2;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .Zero(Zero), .PCWrite(PCWrite), .PCSel(PCSel), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .ExtOp(ExtOp), .state(state),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  mc_controller #(.MEM_HS(1'b0), .CNT_W(4)) dut_wrap (
    .clk(clk), .reset(reset), .Instr(instr2), .imem_ready(rdy2), .dmem_ready(rdy2),
    .Zero(rdy2), .PCWrite(pcw2), .PCSel(pcs2), .IRWrite(irw2), .RegWrite(rw2),
    .RegDst(rd2), .MemtoReg(mtr2), .MemRead(mr2), .MemWrite(mw2),
    .ALUSrc(as2), .ALUCtrl(alu2), .ExtOp(ext2), .state(st2),
    .instr_done(done2), .instr_count(count2)
  );

  typedef struct {
    int          cycles;
    logic [47:0] trace;
    int          irw;
    logic [3:0]  pcmask;
    int          rw;
    logic [1:0]  rd;
    logic [1:0]  mtr;
    int          mr;
    int          mw;
    logic [1:0]  dext;
    logic [6:0]  exw;
    logic [6:0]  memw;
    int          stray;
    logic [31:0] cnt;
  } rec_t;

  rec_t        q[$];
  rec_t        acc, mon_e;
  int          n_chk = 0, n_err = 0;
  logic [31:0] retired = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t blank();
    rec_t r;
    r.cycles = 0; r.trace = '0; r.irw = 0; r.pcmask = '0; r.rw = 0; r.rd = '0; r.mtr = '0;
    r.mr = 0; r.mw = 0; r.dext = '0; r.exw = '0; r.memw = '0; r.stray = 0; r.cnt = '0;
    return r;
  endfunction

  // Reference: what one instruction should look like end to end, from the ISA-level rules.
  function automatic rec_t model(input int cls, input int wi, input int wd, input bit z,
                                 input logic [31:0] cnt);
    rec_t r = blank();
    bit mem = (cls == C_LW || cls == C_SW);
    bit jmp = (cls == C_BEQ || cls == C_JAL || cls == C_JR);
    bit wb  = (cls == C_ADDU || cls == C_SUBU || cls == C_ORI || cls == C_LUI || cls == C_LW);
    r.cycles = (cls == C_UNK ? 2 : jmp ? 3 : cls == C_LW ? 5 : 4) + wi + (mem ? wd : 0);
    for (int i = 0; i <= wi; i++) r.trace = {r.trace[44:0], 3'd0};
    r.trace = {r.trace[44:0], 3'd1};
    if (cls != C_UNK) r.trace = {r.trace[44:0], 3'd2};
    if (mem) for (int i = 0; i <= wd; i++) r.trace = {r.trace[44:0], 3'd3};
    if (wb) r.trace = {r.trace[44:0], 3'd4};
    r.irw = 1;
    r.pcmask = 4'b0001 | ((cls == C_BEQ && z) ? 4'b0010 : 4'b0) |
               (cls == C_JAL ? 4'b0100 : 4'b0) | (cls == C_JR ? 4'b1000 : 4'b0);
    r.rw  = (wb || cls == C_JAL) ? 1 : 0;
    r.rd  = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
    r.mtr = (cls == C_LW) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
    r.mr  = (cls == C_LW) ? wd + 1 : 0;
    r.mw  = (cls == C_SW) ? wd + 1 : 0;
    r.dext = (cls == C_LUI) ? 2'd1 : mem ? 2'd2 : (cls == C_BEQ) ? 2'd3 : 2'd0;
    case (cls)
      C_ADDU:     r.exw = {4'd2, 1'b0, 2'd0};
      C_SUBU:     r.exw = {4'd6, 1'b0, 2'd0};
      C_ORI:      r.exw = {4'd1, 1'b1, 2'd0};
      C_LUI:      r.exw = {4'd2, 1'b1, 2'd1};
      C_LW, C_SW: r.exw = {4'd2, 1'b1, 2'd2};
      C_BEQ:      r.exw = {4'd6, 1'b0, 2'd3};
      default:    r.exw = 7'd0;
    endcase
    r.memw = mem ? {4'd2, 1'b1, 2'd2} : 7'd0;
    r.cnt  = cnt;
    return r;
  endfunction

  function automatic logic [31:0] enc(input int cls);
    logic [31:0] r = $urandom;
    logic [5:0]  bad_ops [4] = '{6'h3F, 6'h02, 6'h08, 6'h05};
    case (cls)
      C_ADDU: return {6'h00, r[25:6], 6'h21};
      C_SUBU: return {6'h00, r[25:6], 6'h23};
      C_JR:   return {6'h00, r[25:6], 6'h08};
      C_ORI:  return {6'h0D, r[25:0]};
      C_LW:   return {6'h23, r[25:0]};
      C_SW:   return {6'h2B, r[25:0]};
      C_BEQ:  return {6'h04, r[25:0]};
      C_LUI:  return {6'h0F, r[25:0]};
      C_JAL:  return {6'h03, r[25:0]};
      default: begin
        if (r[31]) return {6'h00, r[25:6], 6'h20};
        return {bad_ops[r[30:29]], r[25:0]};
      end
    endcase
  endfunction

  // Drives one instruction's full timeline; noise on Instr/ready outside the cycles that matter.
  task automatic drive(input logic [31:0] ins, input int cls, input int wi, input int wd, input bit z);
    rec_t e = model(cls, wi, wd, z, retired);
    bit   mem = (cls == C_LW || cls == C_SW);
    q.push_back(e);
    retired++;
    for (int k = 0; k < e.cycles; k++) begin
      Zero = z;
      if (k < wi) begin
        imem_ready = 1'b0; Instr = $urandom;
      end else if (k == wi) begin
        imem_ready = 1'b1; Instr = ins;
      end else begin
        imem_ready = 1'($urandom); Instr = $urandom;
      end
      if (mem && k >= wi + 3 && k <= wi + 3 + wd) dmem_ready = (k == wi + 3 + wd);
      else dmem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      acc = blank();
    end else begin
      acc.cycles++;
      acc.trace = {acc.trace[44:0], state};
      if (IRWrite) acc.irw++;
      if (PCWrite) acc.pcmask[PCSel] = 1'b1;
      if (RegWrite) begin
        acc.rw++; acc.rd = RegDst; acc.mtr = MemtoReg;
      end
      if (MemRead) acc.mr++;
      if (MemWrite) acc.mw++;
      if (state == 3'd1) acc.dext = ExtOp;
      if (state == 3'd2) acc.exw = {ALUCtrl, ALUSrc, ExtOp};
      if (state == 3'd3) acc.memw = {ALUCtrl, ALUSrc, ExtOp};
      if ((state == 3'd1 || (state == 3'd0 && !IRWrite)) &&
          (PCWrite || IRWrite || RegWrite || MemRead || MemWrite || ALUSrc || ALUCtrl != 4'd0))
        acc.stray++;
      if (instr_done) begin
        chk("scoreboard_nonempty", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("cycles", acc.cycles, mon_e.cycles);
          chk("state_trace", acc.trace, mon_e.trace);
          chk("irwrite_cycles", acc.irw, mon_e.irw);
          chk("pcwrite_sel_mask", acc.pcmask, mon_e.pcmask);
          chk("regwrite_cycles", acc.rw, mon_e.rw);
          chk("regdst", acc.rd, mon_e.rd);
          chk("memtoreg", acc.mtr, mon_e.mtr);
          chk("memread_cycles", acc.mr, mon_e.mr);
          chk("memwrite_cycles", acc.mw, mon_e.mw);
          chk("decode_extop", acc.dext, mon_e.dext);
          chk("exec_alu_word", acc.exw, mon_e.exw);
          chk("mem_alu_word", acc.memw, mon_e.memw);
          chk("stray_enables", acc.stray, mon_e.stray);
          chk("instr_count_at_done", instr_count, mon_e.cnt);
        end
        acc = blank();
      end
    end
  end

  task automatic chk_zero(input string name);
    chk(name, {PCWrite, PCSel, IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite, ALUSrc,
               ALUCtrl, ExtOp, state, instr_done, instr_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    bit   found;
    int   cls;
    acc = blank();
    Instr = 32'h00221821;
    @(negedge clk); chk_zero("reset_outputs_0");
    @(negedge clk); chk_zero("reset_outputs_1");
    chk("reset_wrap_count", count2, 4'd0);
    @(posedge clk); #1; reset = 1'b0;

    drive(32'h00221821, C_ADDU, 0, 0, 1'b0);
    drive(enc(C_LW), C_LW, 0, 3, 1'b0);
    drive(enc(C_BEQ), C_BEQ, 0, 0, 1'b1);
    drive(enc(C_BEQ), C_BEQ, 0, 0, 1'b0);
    drive(enc(C_JAL), C_JAL, 0, 0, 1'b0);
    drive(enc(C_JR), C_JR, 0, 0, 1'b0);
    drive(32'hFC000000, C_UNK, 0, 0, 1'b0);
    drive(enc(C_SW), C_SW, 2, 1, 1'b1);
    drive(enc(C_ORI), C_ORI, 1, 0, 1'b0);
    drive(enc(C_LUI), C_LUI, 0, 2, 1'b1);
    drive(enc(C_SUBU), C_SUBU, 2, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 9);
      drive(enc(cls), cls, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end
    chk("scoreboard_drained", q.size(), 0);
    chk("count_before_reset", instr_count, retired);

    // Abandon a store mid-access with reset.
    Instr = enc(C_SW); imem_ready = 1'b1; dmem_ready = 1'b0; Zero = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1; imem_ready = 1'b0; Instr = $urandom;
      @(negedge clk);
      if (state == 3'd3) found = 1'b1;
    end
    chk("reached_mem", found, 1'b1);
    chk("memwrite_in_mem", MemWrite, 1'b1);
    @(posedge clk); #1; reset = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    chk_zero("reset_mid_mem_outputs");
    chk("reset_mid_mem_memwrite", MemWrite, 1'b0);
    @(posedge clk); #1; reset = 1'b0; retired = 0;

    fork
      for (int n = 0; n < 16; n++) drive(32'hFC000000, C_UNK, 0, 0, 1'b0);
      begin
        @(negedge clk);
        chk("post_reset_state", state, 3'd0);
        chk("post_reset_count", instr_count, 32'd0);
        chk("post_reset_wrap_count", count2, 4'd0);
        repeat (16) @(negedge clk);
        chk("wrap_count_half", count2, 4'd8);
        repeat (16) @(negedge clk);
        chk("wrap_count_rollover", count2, 4'd0);
      end
    join
    imem_ready = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained_final", q.size(), 0);
    chk("count_after_nops", instr_count, 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit: a Moore-style FSM that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates the datapath control signals per state and latches the opcode/funct internally. It waits on ready handshakes from instruction and data memory, and counts retired instructions. It sits between the instruction register/memory interface and the shared multi-cycle datapath (PC, register file, ALU, extender, data memory), replacing the single-cycle decoder.

## Interface
- MEM_HS, default 1: 1 = honour `imem_ready`/`dmem_ready`; 0 = ignore both and treat them as 1 (fixed one-cycle memory).
- CNT_W, default 32: width of `instr_count`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction memory read data; sampled in FETCH.
- `imem_ready` in 1: instruction read data valid.
- `dmem_ready` in 1: data memory access complete.
- `Zero` in 1: ALU zero flag, used by beq in EXEC.
- `PCWrite` out 1: PC load enable.
- `PCSel` out 2: next-PC source. 00 = PC+4, 01 = branch target, 10 = jump target, 11 = GPR[rs].
- `IRWrite` out 1: instruction register load.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 2: destination register. 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` out 2: write-back source. 00 = ALU, 01 = memory, 10 = PC (already PC+4).
- `MemRead` out 1: data memory read strobe.
- `MemWrite` out 1: data memory write strobe.
- `ALUSrc` out 1: ALU B operand. 0 = GPR[rt], 1 = extended immediate.
- `ALUCtrl` out 4: ALU operation. 0010 = add, 0110 = sub, 0001 = or, 0000 = idle.
- `ExtOp` out 2: immediate extension. 00 = zero, 01 = lui (imm<<16), 10 = sign, 11 = sign<<2.
- `state` out 3: current state, for debug.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- Supported instructions: addu, subu, jr, ori, lw, sw, beq, lui, jal. Any other opcode/funct is an unknown instruction and behaves as a nop.
- FETCH:
  - If `imem_ready` is high, assert `IRWrite=1`, `PCWrite=1`, `PCSel=00`, latch Op = Instr[31:26] and func = Instr[5:0], and go to DECODE.
  - Otherwise hold in FETCH with all enables 0.
- DECODE:
  - All enables are 0; `ExtOp` is driven per the latched instruction.
  - Unknown instruction: pulse `instr_done` and go to FETCH.
  - Otherwise go to EXEC.
- EXEC: `ALUCtrl`, `ALUSrc` and `ExtOp` are driven per instruction.
  - addu: add, ALUSrc 0.
  - subu: sub, ALUSrc 0.
  - ori: or, ALUSrc 1, ExtOp 00.
  - lui: add, ALUSrc 1, ExtOp 01.
  - lw/sw: add, ALUSrc 1, ExtOp 10.
  - beq: sub, ALUSrc 0, ExtOp 11, `PCWrite=Zero`, `PCSel=01`. Then FETCH with `instr_done`.
  - jal: `PCWrite=1`, `PCSel=10`, `RegWrite=1`, `RegDst=10`, `MemtoReg=10`. Then FETCH with `instr_done`.
  - jr: `PCWrite=1`, `PCSel=11`. Then FETCH with `instr_done`.
  - lw/sw go to MEM; all other instructions go to WB.
- MEM:
  - lw holds `MemRead=1`; sw holds `MemWrite=1`. The ALU controls from EXEC stay asserted.
  - Strobes stay held until `dmem_ready` is high. On that cycle lw goes to WB; sw goes to FETCH with `instr_done`.
- WB: `RegWrite=1`, then FETCH with `instr_done`.
  - addu/subu: `RegDst=01`, `MemtoReg=00`.
  - ori/lui: `RegDst=00`, `MemtoReg=00`.
  - lw: `RegDst=00`, `MemtoReg=01`.
- `instr_count` increments by 1 on every `instr_done` and wraps modulo 2^CNT_W.
- Every output not listed for a state is 0.

## Timing
- Reset:
  - While `reset` is high, all outputs are 0, including every write enable and `instr_done`.
  - On the next edge: state = FETCH, latched Op/func = 0, `instr_count` = 0.
  - Reset in any state, including mid-MEM, abandons the instruction; no partial retire is counted.
- Outputs are a combinational function of state, latched Op/func, `Zero` and the ready inputs. They have no register stage.
- Cycle counts with zero wait states:
  - unknown instruction: 2
  - beq, jal, jr: 3
  - addu, subu, ori, lui: 4
  - sw: 4
  - lw: 5
- Each cycle with `imem_ready` or `dmem_ready` low adds exactly one cycle.
- `Instr` changing outside a FETCH-accept cycle has no effect.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state encoding;
  - opcode and funct constants;
  - the ALUCtrl, ExtOp, RegDst, MemtoReg and PCSel encodings.
- Sub-module `mc_decode`: a combinational map from {state, Op, func, Zero} to the control bundle. The top level holds the state register, the Op/func latch, the next-state logic and the counter.

## Test plan
- `reset` held high 2 cycles, then addu $3,$1,$2 (0x00221821) with ready = 1:
  - states 0→1→2→4;
  - WB asserts `RegWrite=1`, `RegDst=01`;
  - `instr_count=1`.
- lw with `dmem_ready` low for 3 cycles:
  - `MemRead` held 4 cycles in MEM, then WB with `MemtoReg=01`;
  - 8 cycles total.
- beq:
  - with `Zero=1` in EXEC: `PCWrite=1`, `PCSel=01`, 3 cycles;
  - with `Zero=0`: `PCWrite=0` and `instr_done` still pulses.
- jal:
  - EXEC asserts `PCWrite=1`, `PCSel=10`, `RegWrite=1`, `RegDst=10`, `MemtoReg=10`;
  - jr (funct 001000): `PCSel=11`.
- Opcode 0x3F returns to FETCH after DECODE with no enables asserted; `instr_count` increments.
- sw with `reset` asserted during MEM:
  - next cycle all outputs are 0 and `MemWrite` drops;
  - state = 0 and `instr_count` = 0.
- CNT_W=4: 16 nops wrap `instr_count` to 0.
